// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//
// Single-clock scan controller for a 4-digit multiplexed 7-segment display.
// A cycle counter divides each digit slot into a BLANK interval (all anodes
// off, to suppress ghosting) followed by a SHOW interval (one anode on). Slots
// are grouped into frames: 4 slots in score mode, 2 slots in timer mode. The
// mode can only change at a frame boundary, either after a minimum dwell
// (auto) or immediately when forced.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   enable      scan enable; 0 blanks the anodes and freezes every counter
//   force_mode  00/11 auto alternate, 01 force score, 10 force timer
//   score_t1    team 1 score, BCD tens [7:4] / units [3:0]
//   score_t2    team 2 score, BCD tens [7:4] / units [3:0]
//   timer_bcd   timer, BCD tens [7:4] / units [3:0]
//   anodo       digit anodes, active-low, bit 3 = leftmost digit
//   digito      BCD digit for the shared segment decoder
//   mode        current mode, 0 = score, 1 = timer
//   frame_tick  one-cycle pulse on the last cycle of each frame
//   scan_state  debug view of the BLANK(0)/SHOW(1) state machine
//
// Handshake: this block has no valid/ready interfaces. Inputs are sampled
// level-wise; score/timer data is captured once per slot on its first cycle.
//
// All outputs are registered from the counter state, so each pin lags the
// counters by exactly one cycle.
module display_scan_scheduler #(
  parameter int DIV_DIGIT    = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int MODE_SLOTS   = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] force_mode,
  input  logic [7:0] score_t1,
  input  logic [7:0] score_t2,
  input  logic [7:0] timer_bcd,
  output logic [3:0] anodo,
  output logic [3:0] digito,
  output logic       mode,
  output logic       frame_tick,
  output logic       scan_state
);

  localparam int CW = (DIV_DIGIT > 1) ? $clog2(DIV_DIGIT) : 1;
  localparam int DW = (MODE_SLOTS > 0) ? $clog2(MODE_SLOTS + 1) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(DIV_DIGIT - 1);
  localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MODE_SLOTS);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] cyc_q;
  logic [1:0]    slot_q;
  logic [DW-1:0] dwell_q;
  logic          mode_q;
  logic [0:0]    state_q;

  logic          slot_end;
  logic          frame_end;
  logic [1:0]    last_slot;
  logic [CW-1:0] cyc_nxt;
  logic [1:0]    slot_nxt;
  logic [DW-1:0] dwell_inc;
  logic [DW-1:0] dwell_nxt;
  logic          mode_nxt;
  logic [0:0]    state_nxt;
  logic [3:0]    map_anode;
  logic [3:0]    map_digit;

  assign scan_state = state_q;

  assign slot_end  = (cyc_q == CYC_LAST);
  assign last_slot = mode_q ? 2'd1 : 2'd3;
  assign frame_end = slot_end && (slot_q == last_slot);
  assign cyc_nxt   = slot_end ? '0 : cyc_q + 1'b1;
  assign slot_nxt  = frame_end ? 2'd0 : (slot_end ? slot_q + 2'd1 : slot_q);
  assign dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;

  // State is a registered decode of the next cycle count, so it always agrees
  // with cyc_q: BLANK for the first BLANK_CYCLES cycles of a slot, SHOW after.
  assign state_nxt = (cyc_nxt >= CYC_BLANK) ? ST_SHOW : ST_BLANK;

  // Mode decision. The dwell used here already counts the slot that is ending,
  // so MODE_SLOTS slots in a mode are enough to trigger an auto toggle.
  always_comb begin
    mode_nxt  = mode_q;
    dwell_nxt = slot_end ? dwell_inc : dwell_q;
    if (frame_end) begin
      case (force_mode)
        2'b01:   mode_nxt = 1'b0;
        2'b10:   mode_nxt = 1'b1;
        default: if (dwell_inc >= DWELL_MAX) mode_nxt = ~mode_q;
      endcase
      if (mode_nxt != mode_q) dwell_nxt = '0;
    end
  end

  always_comb begin
    map_anode = 4'b1111;
    map_digit = 4'd0;
    case ({mode_q, slot_q})
      3'b000: begin map_anode = 4'b0111; map_digit = score_t1[7:4];  end
      3'b001: begin map_anode = 4'b1011; map_digit = score_t1[3:0];  end
      3'b010: begin map_anode = 4'b1101; map_digit = score_t2[7:4];  end
      3'b011: begin map_anode = 4'b1110; map_digit = score_t2[3:0];  end
      3'b100: begin map_anode = 4'b1011; map_digit = timer_bcd[7:4]; end
      3'b101: begin map_anode = 4'b1101; map_digit = timer_bcd[3:0]; end
      default: begin map_anode = 4'b1111; map_digit = 4'd0;          end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q      <= '0;
      slot_q     <= 2'd0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      state_q    <= ST_BLANK;
      anodo      <= 4'b1111;
      digito     <= 4'd0;
      mode       <= 1'b0;
      frame_tick <= 1'b0;
    end else if (enable) begin
      cyc_q      <= cyc_nxt;
      slot_q     <= slot_nxt;
      dwell_q    <= dwell_nxt;
      mode_q     <= mode_nxt;
      state_q    <= state_nxt;
      anodo      <= (state_q == ST_SHOW) ? map_anode : 4'b1111;
      // Data is captured only on the first cycle of a slot so the digit stays
      // stable while its anode is lit.
      if (cyc_q == '0) digito <= map_digit;
      frame_tick <= frame_end;
      mode       <= mode_q;
    end else begin
      anodo      <= 4'b1111;
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] force_mode;
  logic [7:0] score_t1;
  logic [7:0] score_t2;
  logic [7:0] timer_bcd;
  logic [3:0] anodo;
  logic [3:0] digito;
  logic       mode;
  logic       frame_tick;
  logic       scan_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  logic [9:0] exp_q[$];

  display_scan_scheduler #(
    .DIV_DIGIT(4),
    .BLANK_CYCLES(1),
    .MODE_SLOTS(8)
  ) dut (
    .clock(clk),
    .reset(reset),
    .enable(enable),
    .force_mode(force_mode),
    .score_t1(score_t1),
    .score_t2(score_t2),
    .timer_bcd(timer_bcd),
    .anodo(anodo),
    .digito(digito),
    .mode(mode),
    .frame_tick(frame_tick),
    .scan_state(scan_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [1:0] fm;
    logic [7:0] t1;
    logic [3:0] an;
    logic [3:0] dg;
    logic       tk;
    logic       md;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(int n, logic [3:0] an, logic [3:0] dg, logic tk, logic md);
    vec_t v;
    v.n  = n;
    v.fm = 2'b01;
    v.t1 = 8'h42;
    v.an = an;
    v.dg = dg;
    v.tk = tk;
    v.md = md;
    return v;
  endfunction

  // driver tasks
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic step_to(input int n);
    while (cyc_n < n) step();
  endtask

  task automatic do_reset(input logic [1:0] fm);
    @(negedge clk);
    reset      = 1'b1;
    enable     = 1'b1;
    force_mode = fm;
    score_t1   = 8'h42;
    score_t2   = 8'h17;
    timer_bcd  = 8'h59;
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    logic [9:0] e;

    reset      = 1'b1;
    enable     = 1'b1;
    force_mode = 2'b01;
    score_t1   = 8'h42;
    score_t2   = 8'h17;
    timer_bcd  = 8'h59;
    #1;
    chk("reset_anodo", 8'(anodo), 8'hF);
    chk("reset_digito", 8'(digito), 8'h0);
    chk("reset_mode", 8'(mode), 8'h0);
    chk("reset_tick", 8'(frame_tick), 8'h0);

    // Score scan: 1 blank cycle + 3 show cycles per slot, 16-cycle frame.
    vecs[0]  = mkv(1,  4'hF, 4'h4, 1'b0, 1'b0);
    vecs[1]  = mkv(2,  4'h7, 4'h4, 1'b0, 1'b0);
    vecs[2]  = mkv(4,  4'h7, 4'h4, 1'b0, 1'b0);
    vecs[3]  = mkv(5,  4'hF, 4'h2, 1'b0, 1'b0);
    vecs[4]  = mkv(6,  4'hB, 4'h2, 1'b0, 1'b0);
    vecs[5]  = mkv(8,  4'hB, 4'h2, 1'b0, 1'b0);
    vecs[6]  = mkv(9,  4'hF, 4'h1, 1'b0, 1'b0);
    vecs[7]  = mkv(10, 4'hD, 4'h1, 1'b0, 1'b0);
    vecs[8]  = mkv(12, 4'hD, 4'h1, 1'b0, 1'b0);
    vecs[9]  = mkv(13, 4'hF, 4'h7, 1'b0, 1'b0);
    vecs[10] = mkv(14, 4'hE, 4'h7, 1'b0, 1'b0);
    vecs[11] = mkv(15, 4'hE, 4'h7, 1'b0, 1'b0);
    vecs[12] = mkv(16, 4'hE, 4'h7, 1'b1, 1'b0);
    vecs[13] = mkv(17, 4'hF, 4'h4, 1'b0, 1'b0);
    vecs[14] = mkv(18, 4'h7, 4'h4, 1'b0, 1'b0);
    vecs[15] = mkv(31, 4'hE, 4'h7, 1'b0, 1'b0);
    vecs[16] = mkv(32, 4'hE, 4'h7, 1'b1, 1'b0);
    vecs[17] = mkv(33, 4'hF, 4'h4, 1'b0, 1'b0);

    do_reset(2'b01);
    for (int i = 0; i < 18; i++) begin
      force_mode = vecs[i].fm;
      score_t1   = vecs[i].t1;
      exp_q.push_back({vecs[i].an, vecs[i].dg, vecs[i].tk, vecs[i].md});
      step_to(vecs[i].n);
      e = exp_q.pop_front();
      chk($sformatf("scan_anodo[%0d]", i), 8'(anodo), 8'(e[9:6]));
      chk($sformatf("scan_digito[%0d]", i), 8'(digito), 8'(e[5:2]));
      chk($sformatf("scan_tick[%0d]", i), 8'(frame_tick), 8'(e[1]));
      chk($sformatf("scan_mode[%0d]", i), 8'(mode), 8'(e[0]));
    end

    // Auto alternate: 8 score slots, then 8 timer slots.
    do_reset(2'b00);
    step_to(32);
    chk("auto_tick32", 8'(frame_tick), 8'h1);
    chk("auto_mode32", 8'(mode), 8'h0);
    step();
    chk("auto_mode33", 8'(mode), 8'h1);
    chk("auto_anodo33", 8'(anodo), 8'hF);
    chk("auto_digito33", 8'(digito), 8'h5);
    step();
    chk("auto_anodo34", 8'(anodo), 8'hB);
    step_to(38);
    chk("auto_anodo38", 8'(anodo), 8'hD);
    chk("auto_digito38", 8'(digito), 8'h9);
    step_to(40);
    chk("auto_tick40", 8'(frame_tick), 8'h1);
    step_to(64);
    chk("auto_tick64", 8'(frame_tick), 8'h1);
    chk("auto_mode64", 8'(mode), 8'h1);
    step();
    chk("auto_mode65", 8'(mode), 8'h0);
    chk("auto_digito65", 8'(digito), 8'h4);
    step();
    chk("auto_anodo66", 8'(anodo), 8'h7);

    // Forced switch mid-frame must not truncate the score frame.
    do_reset(2'b01);
    step_to(6);
    force_mode = 2'b10;
    step_to(10);
    chk("force_anodo10", 8'(anodo), 8'hD);
    chk("force_mode10", 8'(mode), 8'h0);
    step_to(16);
    chk("force_tick16", 8'(frame_tick), 8'h1);
    chk("force_anodo16", 8'(anodo), 8'hE);
    chk("force_mode16", 8'(mode), 8'h0);
    step();
    chk("force_mode17", 8'(mode), 8'h1);
    chk("force_digito17", 8'(digito), 8'h5);
    step();
    chk("force_anodo18", 8'(anodo), 8'hB);
    step_to(60);
    chk("force_mode60", 8'(mode), 8'h1);

    // Freeze during SHOW of slot 2.
    do_reset(2'b01);
    step_to(10);
    enable = 1'b0;
    step();
    chk("freeze_anodo11", 8'(anodo), 8'hF);
    chk("freeze_digito11", 8'(digito), 8'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("freeze_anodo_hold%0d", k), 8'(anodo), 8'hF);
      chk($sformatf("freeze_tick_hold%0d", k), 8'(frame_tick), 8'h0);
    end
    enable = 1'b1;
    step();
    chk("freeze_resume16", 8'(anodo), 8'hD);
    step_to(20);
    chk("freeze_anodo20", 8'(anodo), 8'hE);
    chk("freeze_tick20", 8'(frame_tick), 8'h0);
    step();
    chk("freeze_tick21", 8'(frame_tick), 8'h1);

    // Mid-slot data change is ignored until the next slot.
    do_reset(2'b01);
    step_to(2);
    score_t1 = 8'h99;
    step();
    chk("data_digito3", 8'(digito), 8'h4);
    step();
    chk("data_digito4", 8'(digito), 8'h4);
    step();
    chk("data_anodo5", 8'(anodo), 8'hF);
    chk("data_digito5", 8'(digito), 8'h9);
    step();
    chk("data_anodo6", 8'(anodo), 8'hB);
    score_t1 = 8'h42;

    // Asynchronous reset during SHOW of timer slot 1.
    do_reset(2'b10);
    step_to(22);
    chk("areset_pre_mode", 8'(mode), 8'h1);
    chk("areset_pre_anodo", 8'(anodo), 8'hD);
    chk("areset_pre_digito", 8'(digito), 8'h9);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_anodo", 8'(anodo), 8'hF);
    chk("areset_mode", 8'(mode), 8'h0);
    chk("areset_digito", 8'(digito), 8'h0);
    chk("areset_tick", 8'(frame_tick), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0;
    step();
    chk("areset_post1", 8'(anodo), 8'hF);
    step();
    chk("areset_post2", 8'(anodo), 8'h7);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Time-division scan controller for the scoreboard's 4-digit multiplexed 7-segment display. It sequences the digit anodes, selects the matching BCD digit for the shared segment decoder, and alternates the display between score mode (team 1 and team 2, two digits each) and timer mode (two centre digits) on a fixed dwell period. Each digit slot begins with a blanking interval to suppress ghosting. It replaces free-running divided clocks as anode selectors with a single-clock, counter-driven scheduler.

## Interface
- DIV_DIGIT, 50000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ BLANK_CYCLES < DIV_DIGIT.
- MODE_SLOTS, 2000: minimum number of slots spent in one mode before a switch.
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable. When 0, all anodes are forced off and all counters freeze.
- force_mode  in  2  mode control:
  - 00 or 11: auto alternate.
  - 01: force score mode.
  - 10: force timer mode.
- score_t1  in  8  team 1 score as BCD: [7:4] tens, [3:0] units.
- score_t2  in  8  team 2 score as BCD: [7:4] tens, [3:0] units.
- timer_bcd  in  8  timer as BCD: [7:4] tens, [3:0] units.
- anodo  out  4  digit anodes, active-low. Bit 3 is the leftmost digit.
- digito  out  4  BCD digit sent to the segment decoder.
- mode  out  1  current mode: 0 = score, 1 = timer.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Counters:
  - cyc: 0..DIV_DIGIT-1, position within the current slot.
  - slot: slot index within the frame.
  - dwell: slots elapsed since the current mode was entered.
- Frame length: score mode = 4 slots; timer mode = 2 slots.
- Score slot map (anodo / digito):
  - slot 0: 0111 / score_t1[7:4]
  - slot 1: 1011 / score_t1[3:0]
  - slot 2: 1101 / score_t2[7:4]
  - slot 3: 1110 / score_t2[3:0]
- Timer slot map (anodo / digito):
  - slot 0: 1011 / timer_bcd[7:4]
  - slot 1: 1101 / timer_bcd[3:0]
- State machine:
  - BLANK: cyc < BLANK_CYCLES. anodo = 1111.
  - SHOW: cyc ≥ BLANK_CYCLES. anodo = mapped value for the current slot.
  - BLANK → SHOW when cyc reaches BLANK_CYCLES.
  - SHOW → BLANK when the slot ends, i.e. cyc reaches DIV_DIGIT-1.
- Input sampling: digito is loaded from the inputs on the first cycle of each slot and held for the whole slot. Input changes mid-slot are ignored until the next slot.
- dwell increments at every slot end and saturates at MODE_SLOTS.
- Mode decision is made only at a frame boundary, in the cycle where frame_tick is asserted:
  - Auto: toggle mode if dwell ≥ MODE_SLOTS; on a toggle, clear dwell.
  - Forced: set mode to the forced value; clear dwell if the mode changed.
  - slot wraps to 0 in all cases.
  - A force_mode change mid-frame never truncates the current frame.
- enable = 0: anodo = 1111 from the next cycle. cyc, slot, dwell, mode and digito hold, and frame_tick = 0. When enable returns to 1, scanning resumes at the frozen cyc and slot.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle, giving one cycle of latency from counter to pin.
- Reset values (asserted asynchronously, immediately on reset = 1):
  - anodo = 1111, digito = 0, mode = 0, frame_tick = 0.
  - cyc = 0, slot = 0, dwell = 0, state = BLANK.
- Reset mid-slot: outputs go to their reset values in the same cycle. After reset is released, the first slot starts at score slot 0 with a full BLANK interval.
- Two anodes are never active in the same cycle. Every change of active anode passes through at least BLANK_CYCLES cycles of 1111.
- frame_tick is high for exactly one cycle. That cycle is the last cycle of slot 3 in score mode, or of slot 1 in timer mode. mode updates on the following cycle, together with the first BLANK cycle of the next frame.
- Defaults at 50 MHz: slot = 1 ms; dwell = 2 s; score frame = 4 ms; timer frame = 2 ms.

## Test plan
Parameters for all scenarios: DIV_DIGIT = 4, BLANK_CYCLES = 1, MODE_SLOTS = 8.
- Score scan: score_t1 = 0x42, score_t2 = 0x17, force_mode = 01 → each slot is 1 cycle of 1111 then 3 cycles of the mapped anode. Sequence is 0111/4, 1011/2, 1101/1, 1110/7. frame_tick fires every 16 cycles.
- Auto alternate: force_mode = 00, timer_bcd = 0x59 → after 2 score frames (32 cycles), mode = 1 and the display shows 1011/5 then 1101/9. After 4 timer frames (32 cycles), mode returns to 0.
- Forced switch mid-frame: force_mode changes 01 → 10 during score slot 1 → slots 2 and 3 complete in score mode; mode = 1 only after frame_tick. Mode then stays 1 indefinitely.
- Freeze: enable drops during SHOW of slot 2 → anodo = 1111 on the next cycle and frame_tick stays 0. Re-enable resumes slot 2 at the same cyc; the frame ends after the remaining cycles.
- Mid-slot data change: score_t1 changes 0x42 → 0x99 during SHOW of slot 0 → digito stays 4 for that slot. Slot 1 shows 9.
- Async reset during SHOW of timer slot 1 → anodo = 1111, mode = 0 and digito = 0 without waiting for a clock edge. After release, the first active anode is 0111 after 1 BLANK cycle.
